// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding and default sizing for the data-memory arbiter.
package dmem_arb_pkg;
   typedef enum logic [1:0] {
      CPU_OWN = 2'd0,
      DMA_ACC = 2'd1,
      DMA_ACK = 2'd2
   } arbState_t;
   localparam int ADDR_W_DEF     = 8;
   localparam int DATA_W_DEF     = 32;
   localparam int STARVE_MAX_DEF = 4;
   function automatic int cntWidth(input int maxVal);
      return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
   endfunction
endpackage

// File: rtl/dmem_arb_perf.sv
// dmem_arb_perf: saturating counters of stalled core cycles and completed DMA accesses.
module dmem_arb_perf (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        ack,
   output logic [31:0] stallCnt,
   output logic [31:0] dmaCnt
);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         stallCnt <= '0;
         dmaCnt   <= '0;
      end else begin
         stallCnt <= stallCnt + 32'(stall && !(&stallCnt));
         dmaCnt   <= dmaCnt + 32'(ack && !(&dmaCnt));
      end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core-priority arbiter for DataMemory with bounded DMA starvation.
// Define DMEM_ARB_PERF_EN to add the perf_stall_cnt / perf_dma_cnt counters.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              owner
`ifdef DMEM_ARB_PERF_EN
   ,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_dma_cnt
`endif
);
   localparam int SW = cntWidth(STARVE_MAX);
   arbState_t     state;
   logic [SW-1:0] starveCnt, starveNext;
   logic          goDma;
   always_comb begin
      starveNext = !dma_req ? '0 :
                   (cpu_req && int'(starveCnt) < STARVE_MAX) ? starveCnt + SW'(1) : starveCnt;
      goDma      = dma_req && (!cpu_req || int'(starveNext) >= STARVE_MAX);
   end
   // owner is a registered copy of (state == DMA_ACC), so dma_req never reaches mem_* directly
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state     <= CPU_OWN;
         starveCnt <= '0;
         owner     <= 1'b0;
         dma_ack   <= 1'b0;
         dma_rdata <= '0;
      end else begin
         case (state)
            CPU_OWN: begin
               state     <= goDma ? DMA_ACC : CPU_OWN;
               starveCnt <= starveNext;
               owner     <= goDma;
               dma_ack   <= 1'b0;
            end
            DMA_ACC: begin
               state     <= DMA_ACK;
               starveCnt <= '0;
               owner     <= 1'b0;
               dma_ack   <= 1'b1;
               if (!dma_we) dma_rdata <= mem_rdata;
            end
            DMA_ACK: begin
               state   <= CPU_OWN;
               owner   <= 1'b0;
               dma_ack <= 1'b0;
            end
            default: begin
               state     <= CPU_OWN;
               starveCnt <= '0;
               owner     <= 1'b0;
               dma_ack   <= 1'b0;
            end
         endcase
      end
   assign mem_addr  = owner ? dma_addr : cpu_addr;
   assign mem_wdata = owner ? dma_wdata : cpu_wdata;
   assign mem_write = owner ? dma_we : cpu_req && cpu_we;
   assign mem_read  = owner ? !dma_we : cpu_req && !cpu_we;
   assign cpu_rdata = mem_rdata;
   assign cpu_stall = owner && cpu_req;
`ifdef DMEM_ARB_PERF_EN
   dmem_arb_perf uPerf (
      .clk     (clk),
      .rst     (rst),
      .stall   (cpu_stall),
      .ack     (dma_ack),
      .stallCnt(perf_stall_cnt),
      .dmaCnt  (perf_dma_cnt)
   );
`endif
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter placed between the MIPS32 core's load/store path and the single-port `DataMemory`, so that a DMA or debug/loader master can read and write data memory while the core runs. The core has priority and sees single-cycle access when granted; DMA accesses are inserted by a 3-state FSM with a bounded-starvation counter. Losing core accesses are signalled by `cpu_stall`, and the SOC freezes PC and register-file writes while it is high.

## Interface
- `ADDR_W`, 8: word-address width, matching the `DataMemory` `addr`.
- `DATA_W`, 32: data width.
- `STARVE_MAX`, 4: number of consecutive core-served cycles allowed while `dma_req` is pending. A value of 0 gives the DMA strict priority.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: core load/store this cycle (`memRead` | `memWrite`).
- `cpu_we` in 1: core write.
- `cpu_addr` in `ADDR_W`: core word address.
- `cpu_wdata` in `DATA_W`: core store data.
- `cpu_rdata` out `DATA_W`: the `mem_rdata` value, passed through combinationally.
- `cpu_stall` out 1: core request not served this cycle.
- `dma_req` in 1: DMA access request, level-sensitive.
- `dma_we` in 1: DMA write.
- `dma_addr` in `ADDR_W`: DMA word address.
- `dma_wdata` in `DATA_W`: DMA write data.
- `dma_rdata` out `DATA_W`: registered DMA read data.
- `dma_ack` out 1: one-cycle completion pulse.
- `mem_addr` out `ADDR_W`, `mem_wdata` out `DATA_W`, `mem_write` out 1, `mem_read` out 1: the `DataMemory` port.
- `mem_rdata` in `DATA_W`: `DataMemory` combinational read data.
- `owner` out 1: 0 = core drives memory, 1 = DMA drives memory.

## Operation
- **States:** `CPU_OWN` (reset), `DMA_ACC`, `DMA_ACK`.
- **`CPU_OWN`:**
  - Memory port driven by the core. `mem_write = cpu_req & cpu_we`; `mem_read = cpu_req & ~cpu_we`. `cpu_stall = 0`.
  - With `dma_req` high and `cpu_req` high, `starve_cnt` increments, saturating at `STARVE_MAX`.
  - Go to `DMA_ACC` when `dma_req & (~cpu_req | starve_cnt_next >= STARVE_MAX)`.
  - `starve_cnt` clears when `dma_req` is low.
- **`DMA_ACC`:**
  - Memory port driven combinationally by the `dma_*` inputs; `owner = 1`; `cpu_stall = cpu_req`.
  - DMA writes commit at the closing posedge. Reads capture `mem_rdata` into `dma_rdata` at the same edge.
  - `starve_cnt` clears. Always go to `DMA_ACK`.
- **`DMA_ACK`:**
  - `dma_ack = 1`. Memory port behaves as in `CPU_OWN`; the core is served and `cpu_stall = 0`.
  - `dma_req` is ignored. Always go to `CPU_OWN`.
- **DMA master rules:**
  - Hold `dma_we`, `dma_addr` and `dma_wdata` stable from `dma_req` rise until `dma_ack`.
  - Drop `dma_req` in the ack cycle, or keep it high to queue the next access.
- **`dma_rdata`:** holds its last value until the next DMA read. It is not updated by DMA writes.
- **Outputs:** all are a function of state and inputs only; there is no combinational path from `dma_req` to `mem_*` outside `DMA_ACC`.

## Timing
- **Reset values:**
  - `state = CPU_OWN`, `starve_cnt = 0`, `dma_ack = 0`, `dma_rdata = 0`, `owner = 0`, `cpu_stall = 0`.
  - `mem_*` follow the core inputs.
- **Core latency:** 0 cycles when not stalled.
- **DMA latency, core idle:** `dma_req` high in cycle n gives `DMA_ACC` in n+1 and `dma_ack` in n+2.
- **DMA latency, core busy:** the core is served for `STARVE_MAX` cycles, then `DMA_ACC`, then `DMA_ACK`.
- **Sustained DMA:** at most one DMA access per 3 cycles.
- **Stall bound:** the core loses at most 1 cycle in every `STARVE_MAX+2` cycles.
- **Reset asserted mid-`DMA_ACC`:** the state returns to `CPU_OWN` immediately (asynchronously). `owner` and the DMA-driven `mem_write` drop at once, no ack is issued, and the write does not commit unless a posedge already occurred.
- **Simultaneous `dma_req` rise and `DMA_ACK`:** `dma_req` is ignored that cycle and re-sampled in `CPU_OWN`.

## Configuration
- **`DMEM_ARB_PERF_EN` defined:**
  - Adds output `perf_stall_cnt` (32 bits): counts cycles with `cpu_stall` high.
  - Adds output `perf_dma_cnt` (32 bits): counts `dma_ack` pulses.
  - Both counters saturate at all-ones and reset to 0.
- **Undefined:** these ports and counters are absent, and the arbitration behaviour is identical.

## Structure
- **Package `dmem_arb_pkg`:**
  - State typedef with encodings `CPU_OWN = 2'd0`, `DMA_ACC = 2'd1`, `DMA_ACK = 2'd2`; `2'd3` recovers to `CPU_OWN`.
  - Default constants for `ADDR_W`, `DATA_W` and `STARVE_MAX`.
- **Sub-module `dmem_arb_perf`:** holds the two saturating counters and is instantiated only under `DMEM_ARB_PERF_EN`.
- **`starve_cnt` width:** `$clog2(STARVE_MAX+1)`, minimum 1.

## Test plan
- **Reset:** hold `rst` = 0 with random inputs. Required: `owner` = 0, `dma_ack` = 0, `dma_rdata` = 0, `cpu_stall` = 0; `mem_addr` tracks `cpu_addr`.
- **DMA write then core read, core idle:** DMA write `0x10` ← `32'hDEADBEEF`, `dma_req` raised in cycle 0. Required: `mem_write` = 1 with `mem_addr = 0x10` in cycle 1, `dma_ack` in cycle 2. A core read of `0x10` in cycle 3 then returns `32'hDEADBEEF` with no stall.
- **Starvation bound:** `cpu_req` high continuously, `STARVE_MAX = 4`, DMA read raised in cycle 0. Required: core served in cycles 0–3, `cpu_stall = 1` and `owner = 1` in cycle 4, `dma_ack` with valid `dma_rdata` in cycle 5.
- **Sustained DMA:** `dma_req` held high, core idle. Required: `dma_ack` in cycles 2, 5 and 8 only, with `DMA_ACK` never followed directly by `DMA_ACC`.
- **Reset mid-access:** `rst` driven low halfway through a `DMA_ACC` write cycle. Required: `mem_write` and `owner` drop immediately, no `dma_ack`, and memory is unchanged.
- **Perf counters (`DMEM_ARB_PERF_EN`):** run the starvation scenario twice. Required: `perf_stall_cnt` = 2 and `perf_dma_cnt` = 2.
